// File: rtl/uart_rx_ctrl_if.sv
// ---------------------------------------------------------------------------
// uart_rx_ctrl_if
// Byte stream leaving the UART receive controller: FIFO head data, its
// error flags and a valid/ready handshake.
//   m_data  : head byte of the receive FIFO
//   m_err   : {parity_err, stop_err} of the head entry
//   m_valid : FIFO holds at least one entry
//   m_ready : consumer accepts the head entry this cycle
// Modports: master = controller side, slave = consumer side.
// ---------------------------------------------------------------------------
interface uart_rx_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] m_data;
  logic [1:0]            m_err;
  logic                  m_valid;
  logic                  m_ready;

  modport master (output m_data, output m_err, output m_valid, input m_ready);
  modport slave  (input m_data, input m_err, input m_valid, output m_ready);
endinterface

// File: rtl/uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_ctrl
// Controller around a UART receiver datapath. Holds the receiver's runtime
// configuration and only applies host updates between frames, watches the
// serial line to track frame activity, classifies each finished frame,
// buffers good bytes in a small FIFO and keeps saturating error/overrun
// statistics.
//
// Optional feature macro: UART_RX_CTRL_KEEP_ERR_FRAMES_EN
//   defined   : errored frames are pushed with m_err set
//   undefined : errored frames are dropped, m_err tied to 0
//
// Ports
//   rx_clk, rst_n          : oversampling clock, async active-low reset
//   rx_in                  : serial line (monitored)
//   cfg_prescale/parity_*  : requested configuration, captured on cfg_update
//   prescale/parity_*      : active configuration driven to the receiver
//   p_data, data_valid,
//   stop_error,parity_error: receiver results
//   m_if (master)          : byte FIFO consumer port
//   cfg_pending/cfg_reject : update status
//   frame_timeout          : pulse, frame ended without receiver event
//   frame_err_cnt,
//   overrun_cnt, cnt_clr   : saturating statistics and their clear
// ---------------------------------------------------------------------------
module uart_rx_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6,
  parameter int FIFO_DEPTH     = 4,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                      rx_clk,
  input  logic                      rst_n,
  input  logic                      rx_in,
  input  logic [PRESCALE_WIDTH-1:0] cfg_prescale,
  input  logic                      cfg_parity_enable,
  input  logic                      cfg_parity_type,
  input  logic                      cfg_update,
  output logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      parity_enable,
  output logic                      parity_type,
  input  logic [DATA_WIDTH-1:0]     p_data,
  input  logic                      data_valid,
  input  logic                      stop_error,
  input  logic                      parity_error,
  uart_rx_ctrl_if.master            m_if,
  output logic                      cfg_pending,
  output logic                      cfg_reject,
  output logic                      frame_timeout,
  output logic [CNT_WIDTH-1:0]      frame_err_cnt,
  output logic [CNT_WIDTH-1:0]      overrun_cnt,
  input  logic                      cnt_clr
);

  localparam int TW = PRESCALE_WIDTH + 4;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(FIFO_DEPTH);
`ifdef UART_RX_CTRL_KEEP_ERR_FRAMES_EN
  localparam int EW = DATA_WIDTH + 2;
`else
  localparam int EW = DATA_WIDTH;
`endif

  typedef enum logic [1:0] {S_IDLE, S_FRAME, S_DONE} state_t;

  state_t                    r_state, w_state_next;
  logic [PRESCALE_WIDTH-1:0] r_prescale, r_pend_prescale;
  logic                      r_parity_enable, r_parity_type;
  logic                      r_pend_parity_enable, r_pend_parity_type;
  logic                      r_cfg_pending, r_cfg_reject, r_frame_timeout;
  logic [TW-1:0]             r_timer;
  logic [CNT_WIDTH-1:0]      r_frame_err_cnt, r_overrun_cnt;
  logic [EW-1:0]             r_mem [FIFO_DEPTH];
  logic [AW-1:0]             r_wr_ptr, r_rd_ptr;
  logic [AW:0]               r_count;

  logic          w_cfg_legal, w_event, w_glitch, w_timer_expire;
  logic          w_apply, w_start, w_timeout;
  logic [TW-1:0] w_load, w_elapsed, w_half;
  logic          w_push_req, w_push, w_pop, w_full, w_overrun, w_err_inc;
  logic [EW-1:0] w_push_entry, w_head;

  assign w_cfg_legal = (cfg_prescale == PRESCALE_WIDTH'(8))  ||
                       (cfg_prescale == PRESCALE_WIDTH'(16)) ||
                       (cfg_prescale == PRESCALE_WIDTH'(32));

  // Frame window in oversampling ticks: (frame bits + 1) * prescale,
  // where a frame is 10 bits, or 11 with parity.
  assign w_load    = (r_parity_enable ? TW'(12) : TW'(11)) * TW'(r_prescale);
  assign w_elapsed = w_load - r_timer;
  assign w_half    = TW'(r_prescale >> 1);

  assign w_event        = data_valid | stop_error | parity_error;
  assign w_glitch       = rx_in && (w_elapsed < w_half);
  assign w_timer_expire = (r_timer == TW'(1));

  // State register
  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next state. A pending config is applied before a start bit is looked at,
  // so a frame can never begin in the same cycle the settings change.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:  if (!r_cfg_pending && !rx_in) w_state_next = S_FRAME;
      S_FRAME: begin
        if (w_event)             w_state_next = S_DONE;
        else if (w_glitch)       w_state_next = S_IDLE;
        else if (w_timer_expire) w_state_next = S_IDLE;
      end
      S_DONE:  if (rx_in) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // State-decoded controls
  always_comb begin
    w_apply   = 1'b0;
    w_start   = 1'b0;
    w_timeout = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_apply = r_cfg_pending;
        w_start = !r_cfg_pending && !rx_in;
      end
      S_FRAME: w_timeout = !w_event && !w_glitch && w_timer_expire;
      default: ;
    endcase
  end

  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n)                 r_timer <= '0;
    else if (w_start)           r_timer <= w_load;
    else if (r_state == S_FRAME) r_timer <= r_timer - TW'(1);
  end

  // A legal update arriving in the apply cycle wins over the clear, so the
  // newer request stays pending and is applied on the next idle cycle.
  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prescale           <= PRESCALE_WIDTH'(32);
      r_parity_enable      <= 1'b0;
      r_parity_type        <= 1'b0;
      r_pend_prescale      <= PRESCALE_WIDTH'(32);
      r_pend_parity_enable <= 1'b0;
      r_pend_parity_type   <= 1'b0;
      r_cfg_pending        <= 1'b0;
      r_cfg_reject         <= 1'b0;
    end else begin
      r_cfg_reject <= cfg_update && !w_cfg_legal;
      if (w_apply) begin
        r_prescale      <= r_pend_prescale;
        r_parity_enable <= r_pend_parity_enable;
        r_parity_type   <= r_pend_parity_type;
      end
      if (cfg_update && w_cfg_legal) begin
        r_pend_prescale      <= cfg_prescale;
        r_pend_parity_enable <= cfg_parity_enable;
        r_pend_parity_type   <= cfg_parity_type;
        r_cfg_pending        <= 1'b1;
      end else if (w_apply) begin
        r_cfg_pending <= 1'b0;
      end
    end
  end

  // Frame classification is independent of the FSM state.
`ifdef UART_RX_CTRL_KEEP_ERR_FRAMES_EN
  assign w_push_req   = w_event;
  assign w_push_entry = {parity_error, stop_error, p_data};
  assign m_if.m_err   = w_head[EW-1 -: 2];
`else
  assign w_push_req   = data_valid && !stop_error && !parity_error;
  assign w_push_entry = p_data;
  assign m_if.m_err   = 2'b00;
`endif

  assign w_full    = (r_count == DEPTH_CNT);
  assign w_pop     = (r_count != '0) && m_if.m_ready;
  assign w_push    = w_push_req && (!w_full || w_pop);
  assign w_overrun = w_push_req && w_full && !w_pop;
  assign w_err_inc = stop_error || parity_error || w_timeout;

  always_ff @(posedge rx_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_push_entry;
  end

  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + (AW+1)'(1);
      else if (!w_push && w_pop) r_count <= r_count - (AW+1)'(1);
    end
  end

  // Statistics saturate at all-ones; clear beats a simultaneous increment.
  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_err_cnt <= '0;
      r_overrun_cnt   <= '0;
      r_frame_timeout <= 1'b0;
    end else begin
      r_frame_timeout <= w_timeout;
      if (cnt_clr) begin
        r_frame_err_cnt <= '0;
        r_overrun_cnt   <= '0;
      end else begin
        if (w_err_inc && (r_frame_err_cnt != '1))
          r_frame_err_cnt <= r_frame_err_cnt + CNT_WIDTH'(1);
        if (w_overrun && (r_overrun_cnt != '1))
          r_overrun_cnt <= r_overrun_cnt + CNT_WIDTH'(1);
      end
    end
  end

  assign w_head        = r_mem[r_rd_ptr];
  assign m_if.m_data   = w_head[DATA_WIDTH-1:0];
  assign m_if.m_valid  = (r_count != '0);
  assign prescale      = r_prescale;
  assign parity_enable = r_parity_enable;
  assign parity_type   = r_parity_type;
  assign cfg_pending   = r_cfg_pending;
  assign cfg_reject    = r_cfg_reject;
  assign frame_timeout = r_frame_timeout;
  assign frame_err_cnt = r_frame_err_cnt;
  assign overrun_cnt   = r_overrun_cnt;

endmodule
